sys_ram_ctrl: RTL and testbench

Parametrised successor to the system data RAM: a single-port data memory with an explicit, checked write-source selector (ALU result or port-pin data), a registered RAM Data Register (RDR), a power-up clear sequencer and sticky bus-error reporting. It sits between the ALU/port-pin datapath and the control ROM's address field. It replaces the multiply-driven shared data wire with a validated 2:1 source selection and adds write-first read forwarding.

---
 rtl/sysram_pkg.sv | 35 +++
 rtl/sys_ram_ctrl_if.sv | 34 +++
 rtl/sys_ram_array.sv | 26 ++
 rtl/sys_ram_ctrl.sv | 133 +++++++++++++
 tb/tb_sys_ram_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/sysram_pkg.sv
// Shared types for the system data RAM controller: FSM states, error codes and
// the write-source selection result.
package sysram_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_CONFLICT = 2'd1,
    ERR_NOSRC    = 2'd2,
    ERR_RANGE    = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_PORT,
    SRC_CONFLICT
  } src_e;

  function automatic src_e src_select(input logic alu_vld, input logic port_vld);
    src_e sel;
    case ({port_vld, alu_vld})
      2'b01:   sel = SRC_ALU;
      2'b10:   sel = SRC_PORT;
      2'b11:   sel = SRC_CONFLICT;
      default: sel = SRC_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/sys_ram_ctrl_if.sv
// Access bus between the datapath/control ROM (master) and the RAM controller
// (slave): request strobes, write candidates, RDR and status.
interface sys_ram_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              RAM_CS;
  logic              RAM_WE;
  logic              RAM_OE;
  logic [ADDR_W-1:0] ADDR;
  logic              ALU_VALID;
  logic [DATA_W-1:0] ALU_DATA;
  logic              PORT_VALID;
  logic [DATA_W-1:0] PORT_DATA;
  logic              RDR_EN;
  logic              ERR_CLR;
  logic [DATA_W-1:0] RDR;
  logic              RD_VALID;
  logic              RAM_READY;
  logic              BUS_ERR;
  logic [1:0]        ERR_CODE;

  modport master (
    output RAM_CS, RAM_WE, RAM_OE, ADDR, ALU_VALID, ALU_DATA,
           PORT_VALID, PORT_DATA, RDR_EN, ERR_CLR,
    input  RDR, RD_VALID, RAM_READY, BUS_ERR, ERR_CODE
  );

  modport slave (
    input  RAM_CS, RAM_WE, RAM_OE, ADDR, ALU_VALID, ALU_DATA,
           PORT_VALID, PORT_DATA, RDR_EN, ERR_CLR,
    output RDR, RD_VALID, RAM_READY, BUS_ERR, ERR_CODE
  );
endinterface

// File: rtl/sys_ram_array.sv
// DEPTH x DATA_W storage: synchronous single write port, combinational read.
// Reads beyond DEPTH return zero so no undefined word ever leaks out.
module sys_ram_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdat,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdat
);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdat;
    end
  end

  assign rdat = ({1'b0, raddr} < DEPTH_X) ? mem_q[raddr] : '0;
endmodule

// File: rtl/sys_ram_ctrl.sv
// Data RAM controller: power-up clear, checked ALU/port write-source select,
// write-first RDR load and sticky first-error capture.
module sys_ram_ctrl
  import sysram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic         CLK,
  input  logic         RST,
  sys_ram_ctrl_if.slave bus
);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH-1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rdr_q, rdr_d;
  logic              rd_valid_q, rd_valid_d;
  logic              ready_q, ready_d;
  logic              bus_err_q, bus_err_d;
  err_e              err_code_q, err_code_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdat;
  logic [DATA_W-1:0] mem_rdat;

  src_e src;
  err_e err_now;
  logic in_range, wr_req, rd_req, wr_ok;

  sys_ram_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk  (CLK),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdat (mem_wdat),
    .raddr(bus.ADDR),
    .rdat (mem_rdat)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdr_d      = rdr_q;
    rd_valid_d = 1'b0;
    ready_d    = ready_q;
    bus_err_d  = bus_err_q;
    err_code_d = err_code_q;
    err_now    = ERR_NONE;
    wr_ok      = 1'b0;

    in_range  = {1'b0, bus.ADDR} < DEPTH_X;
    src       = src_select(bus.ALU_VALID, bus.PORT_VALID);
    wr_req    = bus.RAM_CS & bus.RAM_WE;
    rd_req    = bus.RAM_CS & bus.RAM_OE;
    mem_we    = 1'b0;
    mem_waddr = bus.ADDR;
    mem_wdat  = (src == SRC_PORT) ? bus.PORT_DATA : bus.ALU_DATA;

    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdat  = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        if ((wr_req || rd_req) && !in_range) begin
          err_now = ERR_RANGE;
        end else if (wr_req && src == SRC_CONFLICT) begin
          err_now = ERR_CONFLICT;
        end else if (wr_req && src == SRC_NONE) begin
          err_now = ERR_NOSRC;
        end

        wr_ok  = wr_req && in_range && (src == SRC_ALU || src == SRC_PORT);
        mem_we = wr_ok;

        // Same-cycle write to the shared address wins over the stored word.
        if (rd_req && bus.RDR_EN && in_range) begin
          rdr_d      = wr_ok ? mem_wdat : mem_rdat;
          rd_valid_d = 1'b1;
        end

        if (bus.ERR_CLR) begin
          bus_err_d  = 1'b0;
          err_code_d = ERR_NONE;
        end
        if (err_now != ERR_NONE && !bus_err_d) begin
          bus_err_d  = 1'b1;
          err_code_d = err_now;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      rdr_q      <= '0;
      rd_valid_q <= 1'b0;
      ready_q    <= 1'b0;
      bus_err_q  <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdr_q      <= rdr_d;
      rd_valid_q <= rd_valid_d;
      ready_q    <= ready_d;
      bus_err_q  <= bus_err_d;
      err_code_q <= err_code_d;
    end
  end

  assign bus.RDR       = rdr_q;
  assign bus.RD_VALID  = rd_valid_q;
  assign bus.RAM_READY = ready_q;
  assign bus.BUS_ERR   = bus_err_q;
  assign bus.ERR_CODE  = err_code_q;
endmodule

// File: tb/tb_sys_ram_ctrl.sv
// Bench for sys_ram_ctrl: a DEPTH=32 and a DEPTH=20 instance, each checked every
// cycle against a word-array model, plus directed literal expectations.
module tb_sys_ram_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  sys_ram_ctrl_if #(.DATA_W(8), .ADDR_W(5)) b0 ();
  sys_ram_ctrl_if #(.DATA_W(8), .ADDR_W(5)) b1 ();

  sys_ram_ctrl #(.DATA_W(8), .ADDR_W(5), .DEPTH(32)) dut0 (.CLK(CLK), .RST(RST), .bus(b0));
  sys_ram_ctrl #(.DATA_W(8), .ADDR_W(5), .DEPTH(20)) dut1 (.CLK(CLK), .RST(RST), .bus(b1));

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Model: INIT clears one word per cycle; RUN applies write then read (write-first).
  logic [7:0] m_mem  [2][32];
  int         m_cnt  [2];
  logic [7:0] m_rdr  [2];
  logic       m_rv   [2];
  logic       m_rdy  [2];
  logic       m_err  [2];
  logic [1:0] m_code [2];

  task automatic mreset(int k);
    m_cnt[k] = 0; m_rdr[k] = 8'h00; m_rv[k] = 1'b0;
    m_rdy[k] = 1'b0; m_err[k] = 1'b0; m_code[k] = 2'd0;
  endtask

  task automatic mstep(int k, int depth, logic cs, logic we, logic oe, logic rden,
                       logic av, logic pv, logic clr, logic [4:0] a,
                       logic [7:0] ad, logic [7:0] pd);
    int e;
    int ai;
    ai = int'(a);
    m_rv[k] = 1'b0;
    if (m_cnt[k] < depth) begin
      m_mem[k][m_cnt[k]] = 8'h00;
      m_cnt[k]++;
      if (m_cnt[k] == depth) m_rdy[k] = 1'b1;
      return;
    end
    e = 0;
    if (cs && (we || oe) && ai >= depth) e = 3;
    else if (cs && we && av && pv)      e = 1;
    else if (cs && we && !av && !pv)    e = 2;
    if (clr) begin m_err[k] = 1'b0; m_code[k] = 2'd0; end
    if (e != 0 && !m_err[k]) begin m_err[k] = 1'b1; m_code[k] = 2'(e); end
    if (cs && we && ai < depth && (av ^ pv)) m_mem[k][ai] = av ? ad : pd;
    if (cs && oe && rden && ai < depth) begin
      m_rdr[k] = m_mem[k][ai];
      m_rv[k]  = 1'b1;
    end
  endtask

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      mreset(0);
      mreset(1);
    end else begin
      mstep(0, 32, b0.RAM_CS, b0.RAM_WE, b0.RAM_OE, b0.RDR_EN, b0.ALU_VALID,
            b0.PORT_VALID, b0.ERR_CLR, b0.ADDR, b0.ALU_DATA, b0.PORT_DATA);
      mstep(1, 20, b1.RAM_CS, b1.RAM_WE, b1.RAM_OE, b1.RDR_EN, b1.ALU_VALID,
            b1.PORT_VALID, b1.ERR_CLR, b1.ADDR, b1.ALU_DATA, b1.PORT_DATA);
    end
  end

  always @(negedge CLK) begin
    chk("m0.RDR",       b0.RDR,       m_rdr[0]);
    chk("m0.RD_VALID",  b0.RD_VALID,  m_rv[0]);
    chk("m0.RAM_READY", b0.RAM_READY, m_rdy[0]);
    chk("m0.BUS_ERR",   b0.BUS_ERR,   m_err[0]);
    chk("m0.ERR_CODE",  b0.ERR_CODE,  m_code[0]);
    chk("m1.RDR",       b1.RDR,       m_rdr[1]);
    chk("m1.RD_VALID",  b1.RD_VALID,  m_rv[1]);
    chk("m1.RAM_READY", b1.RAM_READY, m_rdy[1]);
    chk("m1.BUS_ERR",   b1.BUS_ERR,   m_err[1]);
    chk("m1.ERR_CODE",  b1.ERR_CODE,  m_code[1]);
  end

  task automatic drv(int k, logic cs, logic we, logic oe, logic rden, logic av,
                     logic pv, logic clr, logic [4:0] a, logic [7:0] ad, logic [7:0] pd);
    if (k == 0) begin
      b0.RAM_CS = cs; b0.RAM_WE = we; b0.RAM_OE = oe; b0.RDR_EN = rden;
      b0.ALU_VALID = av; b0.PORT_VALID = pv; b0.ERR_CLR = clr;
      b0.ADDR = a; b0.ALU_DATA = ad; b0.PORT_DATA = pd;
    end else begin
      b1.RAM_CS = cs; b1.RAM_WE = we; b1.RAM_OE = oe; b1.RDR_EN = rden;
      b1.ALU_VALID = av; b1.PORT_VALID = pv; b1.ERR_CLR = clr;
      b1.ADDR = a; b1.ALU_DATA = ad; b1.PORT_DATA = pd;
    end
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 8'h00, 8'h00);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 5'd0, 8'h00, 8'h00);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int n;
    int n1;
    idle();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_rdr",    b0.RDR, 8'h00);
    chk("rst_rv",     b0.RD_VALID, 1'b0);
    chk("rst_ready",  b0.RAM_READY, 1'b0);
    chk("rst_buserr", b0.BUS_ERR, 1'b0);
    chk("rst_code",   b0.ERR_CODE, 2'd0);

    // INIT length, with junk accesses that must be ignored
    RST = 1'b0;
    n = 0; n1 = 0;
    while (!(b0.RAM_READY && b1.RAM_READY) && n < 200) begin
      if (n < 10) begin
        drv(0, 1, 1, 1, 1, 1, 1, 0, n[4:0], 8'h55, 8'hAA);
        drv(1, 1, 1, 1, 1, 1, 0, 0, 5'd25, 8'h66, 8'h00);
      end else begin
        idle();
      end
      step();
      n++;
      if (b1.RAM_READY && n1 == 0) n1 = n;
    end
    chk("init_cycles_32", n, 32);
    chk("init_cycles_20", n1, 20);
    chk("init_no_err0", b0.BUS_ERR, 1'b0);
    chk("init_no_err1", b1.BUS_ERR, 1'b0);

    for (int a = 0; a < 32; a++) begin
      drv(0, 1, 0, 1, 1, 0, 0, 0, a[4:0], 8'h00, 8'h00);
      step();
      chk("clear_read", b0.RDR, 8'h00);
    end
    chk("clear_rv", b0.RD_VALID, 1'b1);

    drv(0, 1, 1, 0, 0, 1, 0, 0, 5'd5, 8'hA5, 8'h00); step();
    chk("wr5_no_rv", b0.RD_VALID, 1'b0);
    drv(0, 1, 0, 1, 1, 0, 0, 0, 5'd5, 8'h00, 8'h00); step();
    chk("rd5_rdr", b0.RDR, 8'hA5);
    chk("rd5_rv", b0.RD_VALID, 1'b1);
    idle(); step();
    chk("rd5_rv_pulse", b0.RD_VALID, 1'b0);
    chk("rd5_hold", b0.RDR, 8'hA5);

    drv(0, 1, 1, 1, 1, 0, 1, 0, 5'd7, 8'h99, 8'h3C); step();
    chk("fwd7_rdr", b0.RDR, 8'h3C);
    chk("fwd7_err", b0.BUS_ERR, 1'b0);

    drv(0, 1, 1, 1, 1, 1, 1, 0, 5'd9, 8'h11, 8'h22); step();
    chk("conf_buserr", b0.BUS_ERR, 1'b1);
    chk("conf_code", b0.ERR_CODE, 2'd1);
    chk("conf_old_rdr", b0.RDR, 8'h00);
    drv(0, 1, 1, 0, 0, 0, 0, 0, 5'd9, 8'h00, 8'h00); step();
    chk("sticky_code", b0.ERR_CODE, 2'd1);
    drv(0, 1, 0, 1, 1, 0, 0, 0, 5'd9, 8'h00, 8'h00); step();
    chk("conf_unchanged", b0.RDR, 8'h00);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 5'd0, 8'h00, 8'h00); step();
    chk("clr_buserr", b0.BUS_ERR, 1'b0);
    chk("clr_code", b0.ERR_CODE, 2'd0);
    drv(0, 1, 1, 0, 0, 0, 0, 1, 5'd4, 8'h00, 8'h00); step();
    chk("clr_err_wins", b0.ERR_CODE, 2'd2);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 5'd0, 8'h00, 8'h00); step();

    drv(0, 1, 0, 1, 1, 0, 0, 0, 5'd7, 8'h00, 8'h00); step();
    drv(0, 1, 0, 1, 0, 0, 0, 0, 5'd5, 8'h00, 8'h00); step();
    chk("oe_no_en_hold", b0.RDR, 8'h3C);
    chk("oe_no_en_rv", b0.RD_VALID, 1'b0);

    for (int i = 0; i < 4; i++) begin
      drv(0, 1, 1, 0, 0, 1, 0, 0, 5'(10 + i), 8'(8'h40 + i), 8'h00);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drv(0, 1, 0, 1, 1, 0, 0, 0, 5'(10 + i), 8'h00, 8'h00);
      step();
      chk("b2b_read", b0.RDR, 8'(8'h40 + i));
    end
    idle();

    drv(1, 1, 1, 0, 0, 1, 0, 0, 5'd25, 8'h77, 8'h00); step();
    chk("d20_range_code", b1.ERR_CODE, 2'd3);
    chk("d20_range_err", b1.BUS_ERR, 1'b1);
    drv(1, 1, 0, 1, 1, 0, 0, 0, 5'd25, 8'h00, 8'h00); step();
    chk("d20_range_rv", b1.RD_VALID, 1'b0);
    drv(1, 0, 0, 0, 0, 0, 0, 1, 5'd0, 8'h00, 8'h00); step();
    drv(1, 1, 1, 0, 0, 0, 0, 0, 5'd2, 8'h00, 8'h00); step();
    chk("d20_nosrc", b1.ERR_CODE, 2'd2);
    drv(1, 1, 1, 0, 0, 1, 0, 0, 5'd19, 8'h5A, 8'h00); step();
    drv(1, 1, 0, 1, 1, 0, 0, 0, 5'd19, 8'h00, 8'h00); step();
    chk("d20_last_word", b1.RDR, 8'h5A);
    idle();

    drv(0, 1, 1, 1, 1, 1, 0, 0, 5'd3, 8'hFF, 8'h00); step();
    chk("pre_rst_rdr", b0.RDR, 8'hFF);
    idle();
    RST = 1'b1;
    #1;
    chk("midrst_rdr", b0.RDR, 8'h00);
    chk("midrst_ready", b0.RAM_READY, 1'b0);
    step();
    RST = 1'b0;
    n = 0;
    while (!b0.RAM_READY && n < 200) begin
      step();
      n++;
    end
    chk("reinit_cycles", n, 32);
    drv(0, 1, 0, 1, 1, 0, 0, 0, 5'd3, 8'h00, 8'h00); step();
    chk("reinit_addr3", b0.RDR, 8'h00);
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
